// File: rtl/rtc_sched_pkg.sv
// Shared encodings for the RTC mode scheduler: enable codes, state
// encoding, status codes and small helpers that map a state to them.
package rtc_sched_pkg;

  // One-hot sub-machine select codes driven onto enables_o.
  localparam logic [2:0] ENA_INI = 3'b100;
  localparam logic [2:0] ENA_LEE = 3'b010;
  localparam logic [2:0] ENA_ESC = 3'b001;
  localparam logic [2:0] ENA_OFF = 3'b000;

  // Status codes driven onto mode_o.
  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_INI  = 2'd1;
  localparam logic [1:0] MODE_LEE  = 2'd2;
  localparam logic [1:0] MODE_ESC  = 2'd3;

  typedef enum logic [2:0] {
    ST_GAP   = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } sched_state_e;

  // Enable code presented while sitting in a given state.
  function automatic logic [2:0] state_enables(sched_state_e s);
    logic [2:0] e;
    case (s)
      ST_INIT:  e = ENA_INI;
      ST_READ:  e = ENA_LEE;
      ST_WRITE: e = ENA_ESC;
      default:  e = ENA_OFF;
    endcase
    return e;
  endfunction

  // Status code presented while sitting in a given state.
  function automatic logic [1:0] state_mode(sched_state_e s);
    logic [1:0] m;
    case (s)
      ST_INIT:  m = MODE_INI;
      ST_READ:  m = MODE_LEE;
      ST_WRITE: m = MODE_ESC;
      default:  m = MODE_IDLE;
    endcase
    return m;
  endfunction

  // True for states that drive a sub-machine and are guarded by the timeout.
  function automatic logic is_active(sched_state_e s);
    return (s == ST_INIT) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Wrapping counter that emits a one-cycle tick every PERIOD cycles.
// clr_i holds the count at zero and suppresses the tick.
module rtc_tick_gen #(
  parameter int unsigned PERIOD = 10000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the last value, restart on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/rtc_mode_sched.sv
// Mode scheduler for the RTC bus front end. Runs initialisation once after
// reset, then alternates periodic register reads with user-requested writes,
// inserting a dead-time of all-zero enables on every mode change.
// GAP_CYCLES and TIMEOUT must both be at least 1.
module rtc_mode_sched
  import rtc_sched_pkg::*;
#(
  parameter int unsigned READ_PERIOD = 10000000,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ini_done_i,
  input  logic       lee_done_i,
  input  logic       esc_done_i,
  input  logic       prog_req_i,
  output logic [2:0] enables_o,
  output logic [1:0] mode_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  sched_state_e state_q, state_d;
  sched_state_e after_q, after_d;    // state entered when the gap expires
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic          read_pend_q, read_pend_d;
  logic          prog_pend_q, prog_pend_d;
  logic          prog_r_q;
  logic          timeout_q, timeout_d;
  logic [2:0]    enables_q, enables_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          prog_edge;
  logic          to_fire;
  logic          clr_read;
  logic          clr_prog;

  // Read-period tick; held in reset while initialisation is running.
  rtc_tick_gen #(
    .PERIOD (READ_PERIOD)
  ) u_read_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q == ST_INIT),
    .tick_o  (tick)
  );

  assign prog_edge = prog_req_i & ~prog_r_q;

  // State register together with the gap and timeout counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_GAP;
      after_q <= ST_INIT;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; a timeout overrides everything except a same-cycle done.
  always_comb begin
    state_d  = state_q;
    after_d  = after_q;
    gap_d    = gap_q;
    to_fire  = 1'b0;
    clr_read = 1'b0;
    clr_prog = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = after_q;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (ini_done_i) begin
          state_d = ST_GAP;
          after_d = ST_READ;
          gap_d   = '0;
        end else if (to_q == TO_LAST) begin
          to_fire = 1'b1;
        end
      end
      ST_IDLE: begin
        // Enables are already off here, so modes start without a gap.
        if (prog_pend_q) begin
          state_d  = ST_WRITE;
          clr_prog = 1'b1;
        end else if (read_pend_q) begin
          state_d  = ST_READ;
          clr_read = 1'b1;
        end
      end
      ST_READ: begin
        if (lee_done_i) begin
          state_d = ST_GAP;
          after_d = ST_IDLE;
          gap_d   = '0;
        end else if (to_q == TO_LAST) begin
          to_fire = 1'b1;
        end
      end
      ST_WRITE: begin
        // A commit is always followed by a readback, which also serves
        // any periodic read that was waiting.
        if (esc_done_i) begin
          state_d  = ST_GAP;
          after_d  = ST_READ;
          gap_d    = '0;
          clr_read = 1'b1;
        end else if (to_q == TO_LAST) begin
          to_fire = 1'b1;
        end
      end
      default: begin
        state_d = ST_GAP;
        after_d = ST_INIT;
        gap_d   = '0;
      end
    endcase
    if (to_fire) begin
      state_d  = ST_GAP;
      after_d  = ST_INIT;
      gap_d    = '0;
      clr_read = 1'b1;
      clr_prog = 1'b1;
    end
  end

  // Timeout counter: restarts on entry to a driven mode, counts while in it.
  always_comb begin
    to_d = to_q;
    if (is_active(state_d) && (state_d != state_q)) begin
      to_d = '0;
    end else if (is_active(state_q) && (state_d == state_q)) begin
      to_d = to_q + 1'b1;
    end
  end

  // Pending requests and sticky timeout; a new request wins over a clear.
  always_comb begin
    read_pend_d = (read_pend_q & ~clr_read) | tick;
    prog_pend_d = (prog_pend_q & ~clr_prog) | prog_edge;
    timeout_d   = timeout_q | to_fire;
  end

  // Request flags, request edge register and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      read_pend_q <= 1'b0;
      prog_pend_q <= 1'b0;
      prog_r_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      read_pend_q <= read_pend_d;
      prog_pend_q <= prog_pend_d;
      prog_r_q    <= prog_req_i;
      timeout_q   <= timeout_d;
    end
  end

  // Output decode from the next state so registered outputs track state_q.
  always_comb begin
    enables_d = state_enables(state_d);
    mode_d    = state_mode(state_d);
    busy_d    = (enables_d != ENA_OFF);
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      enables_q <= ENA_OFF;
      mode_q    <= MODE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      enables_q <= enables_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
    end
  end

  assign enables_o = enables_q;
  assign mode_o    = mode_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rtc_mode_sched.sv
// Randomised bench for rtc_mode_sched. A behavioural model predicts the
// outputs after each clock edge; predictions go into a queue that a separate
// monitor drains and compares once per cycle.
module tb_rtc_mode_sched;

  localparam int RP   = 20;
  localparam int GC   = 2;
  localparam int TO   = 50;
  localparam int NCYC = 4000;

  // Model phases (bench-local labels).
  localparam int PH_GAP   = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_IDLE  = 2;
  localparam int PH_READ  = 3;
  localparam int PH_WRITE = 4;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       ini_done_i = 1'b0;
  logic       lee_done_i = 1'b0;
  logic       esc_done_i = 1'b0;
  logic       prog_req_i = 1'b0;
  logic [2:0] enables_o;
  logic [1:0] mode_o;
  logic       busy_o;
  logic       timeout_o;

  always #5 clk_i = ~clk_i;

  rtc_mode_sched #(
    .READ_PERIOD (RP),
    .GAP_CYCLES  (GC),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ini_done_i (ini_done_i),
    .lee_done_i (lee_done_i),
    .esc_done_i (esc_done_i),
    .prog_req_i (prog_req_i),
    .enables_o  (enables_o),
    .mode_o     (mode_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  typedef struct packed {
    logic [2:0] ena;
    logic [1:0] mode;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Model state: current phase, where a gap leads, cycles left in the gap,
  // cycles spent in the current mode, cycles since the period last restarted.
  int ph, after, gap_left, tin, per;
  bit rp, pp, prev, sticky;

  task automatic enter(input int p);
    ph  = p;
    tin = 0;
  endtask

  task automatic go_gap(input int target);
    ph       = PH_GAP;
    after    = target;
    gap_left = GC;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input bit rst, input bit i, input bit l, input bit e, input bit p);
    bit tick, pedge, fire;
    if (rst) begin
      go_gap(PH_INIT);
      tin = 0; per = 0; rp = 0; pp = 0; prev = 0; sticky = 0;
      return;
    end
    tick  = (ph != PH_INIT) && (per == RP - 1);
    per   = (ph == PH_INIT) ? 0 : (per + 1) % RP;
    pedge = p && !prev;
    prev  = p;
    fire  = 0;
    case (ph)
      PH_GAP: begin
        gap_left--;
        if (gap_left == 0) enter(after);
      end
      PH_INIT:  if (i) go_gap(PH_READ);
                else if (tin == TO - 1) fire = 1; else tin++;
      PH_IDLE:  if (pp) begin pp = 0; enter(PH_WRITE); end
                else if (rp) begin rp = 0; enter(PH_READ); end
      PH_READ:  if (l) go_gap(PH_IDLE);
                else if (tin == TO - 1) fire = 1; else tin++;
      PH_WRITE: if (e) begin rp = 0; go_gap(PH_READ); end
                else if (tin == TO - 1) fire = 1; else tin++;
      default: ;
    endcase
    if (fire) begin
      sticky = 1; rp = 0; pp = 0;
      go_gap(PH_INIT);
    end
    if (tick) rp = 1;
    if (pedge) pp = 1;
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.ena  = (ph == PH_INIT) ? 3'b100 : (ph == PH_READ) ? 3'b010 :
             (ph == PH_WRITE) ? 3'b001 : 3'b000;
    x.mode = (ph == PH_INIT) ? 2'd1 : (ph == PH_READ) ? 2'd2 :
             (ph == PH_WRITE) ? 2'd3 : 2'd0;
    x.busy = (x.ena != 3'b000);
    x.tmo  = sticky;
    return x;
  endfunction

  // Monitor: one comparison per cycle plus a one-hot sanity check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({enables_o, mode_o, busy_o, timeout_o} !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got ena=%b mode=%0d busy=%b tmo=%b want ena=%b mode=%0d busy=%b tmo=%b",
                   $time, enables_o, mode_o, busy_o, timeout_o, e.ena, e.mode, e.busy, e.tmo);
        end
        total++;
        if ($countones(enables_o) > 1) begin
          bad++;
          $display("FAIL onehot t=%0t got ena=%b want at most one bit set", $time, enables_o);
        end
      end
    end
  end

  // Driver: random stimulus, reactive done pulses, model prediction per cycle.
  initial begin
    int last_ph;
    int dly;
    bit rst, i, l, e;
    last_ph = -1;
    dly     = 0;
    ph = PH_GAP; after = PH_INIT; gap_left = GC; tin = 0; per = 0;
    rp = 0; pp = 0; prev = 0; sticky = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk_i);
      if (ph != last_ph) begin
        // Mostly short service times; occasionally stall into a timeout.
        dly = ($urandom_range(0, 8) == 0) ? 200 : int'($urandom_range(0, 12));
        last_ph = ph;
      end
      rst = (c < 3) || ($urandom_range(0, 499) == 0);
      i = (ph == PH_INIT)  ? (tin >= dly) : ($urandom_range(0, 15) == 0);
      l = (ph == PH_READ)  ? (tin >= dly) : ($urandom_range(0, 15) == 0);
      e = (ph == PH_WRITE) ? (tin >= dly) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) prog_req_i = ~prog_req_i;
      reset_i    = rst;
      ini_done_i = i;
      lee_done_i = l;
      esc_done_i = e;
      model_step(rst, i, l, e, prog_req_i);
      exp_q.push_back(model_out());
    end
    @(posedge clk_i);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
